csr_trap_seq: RTL and testbench
===============================

Name: csr_trap_seq

Overview:
- Trap/return sequencer that owns the single CSR-file write port and read port.
- Accepts ecall/ebreak/illegal/mret requests from the writeback stage.
- Performs the multi-cycle CSR updates (mepc, mcause, mstatus read-modify-write, mtvec fetch), then issues a one-cycle PC redirect to fetch.
- When idle, passes ordinary pipeline CSR instruction reads and writes straight through to the CSR file.

Parameters:
- DATA_WIDTH, 32, CSR data and PC width.
- CSR_AW, 12, CSR address width; the CSR file uses the low 10 bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- trap_valid  in  1  trap request from writeback
- trap_ready  out  1  request accepted when trap_valid & trap_ready
- trap_kind  in  2  0=ecall, 1=mret, 2=ebreak, 3=illegal
- trap_pc  in  DATA_WIDTH  PC of trapping instruction
- pipe_wen  in  1  pipeline CSR write request
- pipe_waddr  in  CSR_AW  pipeline CSR write address
- pipe_wdata  in  DATA_WIDTH  pipeline CSR write data
- pipe_raddr  in  CSR_AW  pipeline CSR read address
- pipe_rdata  out  DATA_WIDTH  pipeline CSR read data
- pipe_stall  out  1  pipeline CSR access blocked this cycle
- csr_wen  out  1  CSR file write enable
- csr_waddr  out  CSR_AW  CSR file write address
- csr_wdata  out  DATA_WIDTH  CSR file write data
- csr_raddr  out  CSR_AW  CSR file read address
- csr_rdata  in  DATA_WIDTH  CSR file read data (combinational)
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  DATA_WIDTH  redirect target
- busy  out  1  sequencer not in IDLE

Behaviour:
- Reset values: all registered outputs 0; state=IDLE; internal pc/cause/status/target registers 0.
- Shared constants: MSTATUS=0x300, MTVEC=0x305, MEPC=0x341, MCAUSE=0x342.
- trap_ready=1 only in IDLE. In all other states the request is held by the producer.
- IDLE:
  - Pass-through: csr_wen=pipe_wen, csr_waddr=pipe_waddr, csr_wdata=pipe_wdata, csr_raddr=pipe_raddr, pipe_rdata=csr_rdata, pipe_stall=0.
  - On accept, latch trap_pc and cause. Cause map: ecall=11, ebreak=3, illegal=2.
  - Next state: ecall/ebreak/illegal -> T_EPC; mret -> R_RDST.
  - If pipe_wen and an accepted trap coincide, the pipeline write is still performed in the accept cycle. The trap sequence starts the next cycle.
- Non-IDLE states: pipe_stall=1, pipe_rdata=0, and the sequencer drives the csr_* ports.
- Trap path:
  - T_EPC: write MEPC=latched pc.
  - T_CAUSE: write MCAUSE=latched cause.
  - T_RDST: raddr=MSTATUS; capture csr_rdata.
  - T_WRST: write mstatus with MPIE(bit7)=old MIE(bit3), MIE=0, MPP(bits12:11)=2'b11; all other bits unchanged.
  - T_VEC: raddr=MTVEC; target={rdata[31:2],2'b00}.
  - REDIR: redirect_valid=1, redirect_pc=target; then -> IDLE.
  - Accept to redirect is 6 cycles.
- Return path:
  - R_RDST: read MSTATUS and capture.
  - R_WRST: write with MIE=MPIE, MPIE=1, MPP=2'b11.
  - R_EPC: raddr=MEPC; target=rdata.
  - REDIR.
  - Accept to redirect is 4 cycles.
- redirect_valid is exactly one cycle wide and is never asserted in IDLE.
- trap_pc/trap_kind changing mid-sequence has no effect, because the values were latched at accept.
- Reset asserted mid-sequence: immediate return to IDLE with outputs 0. No partial write completes after rst_n falls.
- No other CSR addresses are touched. Widths are fixed and all address constants are zero-extended to CSR_AW.

Optional Feature:
- Macro: CSR_TRAP_IRQ_EN.
- When defined:
  - Adds input irq (1 bit, level-sensitive) and an internal shadow copy of mstatus.MIE. The shadow is updated on every sequencer or pipeline write to MSTATUS.
  - In IDLE, when irq & shadow MIE & !trap_valid, the sequencer self-starts the trap path with cause 0x80000007 and pc=trap_pc.
  - trap_valid has priority over irq in the same cycle.
- When undefined: no irq port, and the shadow logic is absent.

Decomposition:
- Package csr_trap_pkg holds:
  - CSR address localparams.
  - trap_kind enum.
  - Cause constants.
  - State enum.
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11).
- One natural sub-module: csr_status_rmw, a combinational function block computing the trap-entry or return mstatus value from the old value.

Test Plan:
- ecall at pc=0x80000100, mtvec preloaded 0x80000803, mstatus=0x8 -> writes mepc=0x80000100, mcause=11, mstatus=0x1880; redirect_pc=0x80000800 exactly 6 cycles after accept.
- mret with mepc=0x80000104, mstatus=0x1880 -> mstatus written 0x1888; redirect_pc=0x80000104 4 cycles after accept.
- Pipeline csrw mscratch(0x340)=0xDEADBEEF during ecall sequence -> pipe_stall=1 until IDLE; write lands only after stall drops, and never collides with sequencer writes.
- Back-to-back trap_valid held high (ecall then illegal) -> second accepted only in IDLE after REDIR; mcause=2 on the second sequence.
- rst_n low during T_WRST -> state IDLE, csr_wen=0 in the reset cycle, redirect_valid never asserted.
- CSR_TRAP_IRQ_EN defined, irq=1 with MIE=1 -> mcause=0x80000007; irq with MIE=0 -> no sequence starts; irq and trap_valid together -> trap_valid served first.

Source files
------------

// File: rtl/csr_trap_pkg.sv
// Shared constants, enums and the cause map for the CSR trap/return sequencer.
package csr_trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_IRQ     = 32'h8000_0007;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [1:0] {
    K_ECALL   = 2'd0,
    K_MRET    = 2'd1,
    K_EBREAK  = 2'd2,
    K_ILLEGAL = 2'd3
  } trap_kind_e;

  typedef enum logic [3:0] {
    S_IDLE, S_T_EPC, S_T_CAUSE, S_T_RDST, S_T_WRST, S_T_VEC,
    S_R_RDST, S_R_WRST, S_R_EPC, S_REDIR
  } state_e;

  function automatic logic [31:0] trap_cause(trap_kind_e k);
    case (k)
      K_ECALL:   return CAUSE_ECALL;
      K_EBREAK:  return CAUSE_EBREAK;
      K_ILLEGAL: return CAUSE_ILLEGAL;
      default:   return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/csr_trap_seq_status_rmw.sv
// Combinational mstatus update for trap entry (is_ret=0) or mret (is_ret=1).
module csr_status_rmw
  import csr_trap_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] old_status,
  input  logic                  is_ret,
  output logic [DATA_WIDTH-1:0] new_status
);

  always_comb begin
    new_status = old_status;
    new_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    if (is_ret) begin
      new_status[MSTATUS_MIE]  = old_status[MSTATUS_MPIE];
      new_status[MSTATUS_MPIE] = 1'b1;
    end else begin
      new_status[MSTATUS_MPIE] = old_status[MSTATUS_MIE];
      new_status[MSTATUS_MIE]  = 1'b0;
    end
  end

endmodule

// File: rtl/csr_trap_seq.sv
// Trap/return sequencer owning the CSR file ports; pipeline passes through when idle.
// Optional level-sensitive interrupt entry is enabled by defining CSR_TRAP_IRQ_EN.
module csr_trap_seq
  import csr_trap_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CSR_AW     = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef CSR_TRAP_IRQ_EN
  input  logic                  irq,
`endif
  input  logic                  trap_valid,
  output logic                  trap_ready,
  input  logic [1:0]            trap_kind,
  input  logic [DATA_WIDTH-1:0] trap_pc,
  input  logic                  pipe_wen,
  input  logic [CSR_AW-1:0]     pipe_waddr,
  input  logic [DATA_WIDTH-1:0] pipe_wdata,
  input  logic [CSR_AW-1:0]     pipe_raddr,
  output logic [DATA_WIDTH-1:0] pipe_rdata,
  output logic                  pipe_stall,
  output logic                  csr_wen,
  output logic [CSR_AW-1:0]     csr_waddr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic [CSR_AW-1:0]     csr_raddr,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  busy
);

  localparam logic [CSR_AW-1:0] A_MSTATUS = CSR_AW'(CSR_MSTATUS);
  localparam logic [CSR_AW-1:0] A_MTVEC   = CSR_AW'(CSR_MTVEC);
  localparam logic [CSR_AW-1:0] A_MEPC    = CSR_AW'(CSR_MEPC);
  localparam logic [CSR_AW-1:0] A_MCAUSE  = CSR_AW'(CSR_MCAUSE);

  state_e                state;
  logic [DATA_WIDTH-1:0] pc_q, cause_q, status_q, target_q, status_new;
  logic                  irq_take;

  csr_status_rmw #(.DATA_WIDTH(DATA_WIDTH)) u_rmw (
    .old_status (status_q),
    .is_ret     (state == S_R_WRST),
    .new_status (status_new)
  );

`ifdef CSR_TRAP_IRQ_EN
  // Shadow MIE tracks every MSTATUS write that reaches the CSR file, from either source.
  logic shadow_mie;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow_mie <= 1'b0;
    else if (csr_wen && csr_waddr == A_MSTATUS) shadow_mie <= csr_wdata[MSTATUS_MIE];
  end
  assign irq_take = irq & shadow_mie & ~trap_valid;
`else
  assign irq_take = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      status_q <= '0;
      target_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (trap_valid) begin
            pc_q    <= trap_pc;
            cause_q <= DATA_WIDTH'(trap_cause(trap_kind_e'(trap_kind)));
            state   <= (trap_kind_e'(trap_kind) == K_MRET) ? S_R_RDST : S_T_EPC;
          end else if (irq_take) begin
            pc_q    <= trap_pc;
            cause_q <= DATA_WIDTH'(CAUSE_IRQ);
            state   <= S_T_EPC;
          end
        end
        S_T_EPC:   state <= S_T_CAUSE;
        S_T_CAUSE: state <= S_T_RDST;
        S_T_RDST: begin
          status_q <= csr_rdata;
          state    <= S_T_WRST;
        end
        S_T_WRST:  state <= S_T_VEC;
        S_T_VEC: begin
          target_q <= {csr_rdata[DATA_WIDTH-1:2], 2'b00};
          state    <= S_REDIR;
        end
        S_R_RDST: begin
          status_q <= csr_rdata;
          state    <= S_R_WRST;
        end
        S_R_WRST:  state <= S_R_EPC;
        S_R_EPC: begin
          target_q <= csr_rdata;
          state    <= S_REDIR;
        end
        default:   state <= S_IDLE;
      endcase
    end
  end

  assign trap_ready = (state == S_IDLE);
  assign busy       = (state != S_IDLE);

  always_comb begin
    csr_wen        = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    csr_raddr      = '0;
    pipe_rdata     = '0;
    pipe_stall     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      S_IDLE: begin
        // Gated by rst_n so nothing lands in the CSR file while reset is held.
        csr_wen    = pipe_wen & rst_n;
        csr_waddr  = pipe_waddr;
        csr_wdata  = pipe_wdata;
        csr_raddr  = pipe_raddr;
        pipe_rdata = csr_rdata;
        pipe_stall = 1'b0;
      end
      S_T_EPC: begin
        csr_wen   = 1'b1;
        csr_waddr = A_MEPC;
        csr_wdata = pc_q;
      end
      S_T_CAUSE: begin
        csr_wen   = 1'b1;
        csr_waddr = A_MCAUSE;
        csr_wdata = cause_q;
      end
      S_T_RDST, S_R_RDST: csr_raddr = A_MSTATUS;
      S_T_WRST, S_R_WRST: begin
        csr_wen   = 1'b1;
        csr_waddr = A_MSTATUS;
        csr_wdata = status_new;
      end
      S_T_VEC: csr_raddr = A_MTVEC;
      S_R_EPC: csr_raddr = A_MEPC;
      S_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_seq.sv
// Directed scoreboard bench for csr_trap_seq with a small behavioural CSR file.
module tb_csr_trap_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trap_valid, trap_ready;
  logic [1:0]  trap_kind;
  logic [31:0] trap_pc;
  logic        pipe_wen;
  logic [11:0] pipe_waddr, pipe_raddr;
  logic [31:0] pipe_wdata, pipe_rdata;
  logic        pipe_stall, csr_wen;
  logic [11:0] csr_waddr, csr_raddr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        redirect_valid, busy;
  logic [31:0] redirect_pc;
`ifdef CSR_TRAP_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  csr_trap_seq dut (
    .clk(clk), .rst_n(rst_n),
`ifdef CSR_TRAP_IRQ_EN
    .irq(irq),
`endif
    .trap_valid(trap_valid), .trap_ready(trap_ready), .trap_kind(trap_kind), .trap_pc(trap_pc),
    .pipe_wen(pipe_wen), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .pipe_raddr(pipe_raddr), .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  // Behavioural CSR file: combinational read, write on clk; pk_* lets the bench preload.
  logic [31:0] mem [1024];
  logic        pk_we = 1'b0;
  logic [11:0] pk_a  = '0;
  logic [31:0] pk_d  = '0;
  assign csr_rdata = mem[csr_raddr[9:0]];
  always @(posedge clk) begin
    if (csr_wen) mem[csr_waddr[9:0]] <= csr_wdata;
    if (pk_we)   mem[pk_a[9:0]]      <= pk_d;
  end

  typedef struct { logic [11:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [31:0] pc; int cyc; } rd_t;
  wr_t wq[$];
  rd_t rq[$];
  int  cyc = 0;
  int  nvec = 0;
  int  nmis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_wr(input logic [11:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a; w.d = d;
    wq.push_back(w);
  endtask

  task automatic exp_redir(input logic [31:0] pc, input int c);
    rd_t r;
    r.pc = pc; r.cyc = c;
    rq.push_back(r);
  endtask

  // One cycle: inputs already driven after negedge; check what commits at the next posedge.
  task automatic tick();
    wr_t w;
    rd_t r;
    #1;
    cyc++;
    if (csr_wen) begin
      if (wq.size() == 0) chk("wr_unexpected", {csr_waddr, csr_wdata}, 64'h0);
      else begin
        w = wq.pop_front();
        chk("wr_addr", csr_waddr, w.a);
        chk("wr_data", csr_wdata, w.d);
      end
    end
    if (redirect_valid) begin
      if (rq.size() == 0) chk("redir_unexpected", redirect_pc, 64'h0);
      else begin
        r = rq.pop_front();
        chk("redir_pc", redirect_pc, r.pc);
        chk("redir_cycle", cyc, r.cyc);
      end
    end
    @(negedge clk);
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    pk_we = 1'b1; pk_a = a; pk_d = d;
    @(posedge clk);
    #1 pk_we = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int acc;
    rst_n = 1'b0; trap_valid = 1'b0; trap_kind = 2'd0; trap_pc = '0;
    pipe_wen = 1'b1; pipe_waddr = 12'h340; pipe_wdata = 32'h1234; pipe_raddr = 12'h305;
`ifdef CSR_TRAP_IRQ_EN
    irq = 1'b0;
`endif
    #12;
    chk("rst_csr_wen", csr_wen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_redirect", redirect_valid, 0);
    chk("rst_stall", pipe_stall, 0);
    pipe_wen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    poke(12'h305, 32'h8000_0803);
    poke(12'h300, 32'h0000_0008);
    #1 chk("idle_rdata", pipe_rdata, 32'h8000_0803);

    // ecall, with a pipeline mscratch write held during the sequence
    trap_valid = 1'b1; trap_kind = 2'd0; trap_pc = 32'h8000_0100;
    acc = cyc + 1;
    exp_wr(12'h341, 32'h8000_0100); exp_wr(12'h342, 32'd11); exp_wr(12'h300, 32'h1880);
    exp_wr(12'h340, 32'hDEAD_BEEF);
    exp_redir(32'h8000_0800, acc + 6);
    #1 chk("ecall_ready", trap_ready, 1);
    tick();
    trap_valid = 1'b0; trap_kind = 2'd3; trap_pc = 32'h1111_1111;
    pipe_wen = 1'b1; pipe_waddr = 12'h340; pipe_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 6; i++) begin
      #1 chk("seq_stall", pipe_stall, 1);
      chk("seq_rdata", pipe_rdata, 0);
      tick();
    end
    #1 chk("idle_stall", pipe_stall, 0);
    tick();
    pipe_wen = 1'b0;
    chk("mem_mepc", mem[12'h341], 32'h8000_0100);
    chk("mem_mcause", mem[12'h342], 32'd11);
    chk("mem_mstatus", mem[12'h300], 32'h1880);
    chk("mem_mscratch", mem[12'h340], 32'hDEAD_BEEF);

    // mret
    poke(12'h341, 32'h8000_0104);
    trap_valid = 1'b1; trap_kind = 2'd1; trap_pc = 32'h0;
    acc = cyc + 1;
    exp_wr(12'h300, 32'h1888);
    exp_redir(32'h8000_0104, acc + 4);
    tick();
    trap_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mret_mstatus", mem[12'h300], 32'h1888);

    // back-to-back: ecall then illegal, trap_valid held
    trap_valid = 1'b1; trap_kind = 2'd0; trap_pc = 32'h8000_0200;
    acc = cyc + 1;
    exp_wr(12'h341, 32'h8000_0200); exp_wr(12'h342, 32'd11); exp_wr(12'h300, 32'h1880);
    exp_redir(32'h8000_0800, acc + 6);
    exp_wr(12'h341, 32'h8000_0300); exp_wr(12'h342, 32'd2); exp_wr(12'h300, 32'h1800);
    exp_redir(32'h8000_0800, acc + 13);
    tick();
    trap_kind = 2'd3; trap_pc = 32'h8000_0300;
    for (int i = 0; i < 6; i++) begin
      #1 chk("b2b_ready", trap_ready, 0);
      tick();
    end
    #1 chk("b2b_ready2", trap_ready, 1);
    tick();
    trap_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("b2b_mcause", mem[12'h342], 32'd2);

    // reset in T_WRST
    trap_valid = 1'b1; trap_kind = 2'd2; trap_pc = 32'h8000_0400;
    exp_wr(12'h341, 32'h8000_0400); exp_wr(12'h342, 32'd3);
    tick();
    trap_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    #1 chk("rstmid_busy", busy, 0);
    chk("rstmid_wen", csr_wen, 0);
    chk("rstmid_redir", redirect_valid, 0);
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("rstmid_mstatus", mem[12'h300], 32'h1800);
    chk("rstmid_mcause", mem[12'h342], 32'd3);

`ifdef CSR_TRAP_IRQ_EN
    // irq with MIE set via a pipeline write
    pipe_wen = 1'b1; pipe_waddr = 12'h300; pipe_wdata = 32'h8;
    exp_wr(12'h300, 32'h8);
    tick();
    pipe_wen = 1'b0;
    irq = 1'b1; trap_pc = 32'h8000_0500;
    acc = cyc + 1;
    exp_wr(12'h341, 32'h8000_0500); exp_wr(12'h342, 32'h8000_0007); exp_wr(12'h300, 32'h1880);
    exp_redir(32'h8000_0800, acc + 6);
    for (int i = 0; i < 7; i++) tick();
    // irq with MIE now clear: nothing starts
    for (int i = 0; i < 4; i++) begin
      #1 chk("irq_mie0_busy", busy, 0);
      tick();
    end
    chk("irq_mcause", mem[12'h342], 32'h8000_0007);
    irq = 1'b0;
    pipe_wen = 1'b1; pipe_waddr = 12'h300; pipe_wdata = 32'h8;
    exp_wr(12'h300, 32'h8);
    tick();
    pipe_wen = 1'b0;
    // irq and trap_valid together: trap wins
    irq = 1'b1; trap_valid = 1'b1; trap_kind = 2'd0; trap_pc = 32'h8000_0600;
    acc = cyc + 1;
    exp_wr(12'h341, 32'h8000_0600); exp_wr(12'h342, 32'd11); exp_wr(12'h300, 32'h1880);
    exp_redir(32'h8000_0800, acc + 6);
    tick();
    trap_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    irq = 1'b0;
    chk("irqprio_mcause", mem[12'h342], 32'd11);
`endif

    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
